apb_regfile_slave: RTL and testbench
====================================

APB_REGFILE_SLAVE -- requirements
Module: apb_regfile_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data bus width (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning byte address width.
REQ-003 SHALL have parameter NUM_REGS, default 8, meaning register count (1..2^(ADDR_W-2)).
REQ-004 SHALL have parameter WAIT_CYCLES, default 0, meaning PREADY-low cycles inserted per access (0..15).
REQ-005 SHALL have parameter RO_MASK, default 0 (NUM_REGS bits), meaning bit i set makes register i read-only.
REQ-006 PCLK  input  1  clock; all logic rising-edge.
REQ-007 PRESET  input  1  reset; one clock; reset is synchronous and active-high.
REQ-008 PSEL  input  1  slave select.
REQ-009 PENABLE  input  1  access phase.
REQ-010 PWRITE  input  1  1 = write, 0 = read.
REQ-011 PADDR  input  ADDR_W  byte address.
REQ-012 PWDATA  input  DATA_W  write data.
REQ-013 PSTRB  input  DATA_W/8  byte write strobes (used only per REQ-030).
REQ-014 PRDATA  output  DATA_W  read data, registered.
REQ-015 PREADY  output  1  transfer complete, registered.
REQ-016 PSLVERR  output  1  error response, valid only while PREADY=1.

Function
REQ-017 FSM states IDLE, SETUP, WAIT, DONE; a state register and a 4-bit wait counter SHALL be the only control state.
REQ-018 IDLE->SETUP when PSEL=1 and PENABLE=0; IDLE with PSEL=1 and PENABLE=1 (no setup phase) SHALL go to DONE with PSLVERR=1 and no register effect.
REQ-019 SETUP->WAIT on the next edge with PSEL=1 and PENABLE=1, loading counter = WAIT_CYCLES; SETUP with PSEL=0 SHALL return to IDLE.
REQ-020 WAIT decrements counter each cycle; at counter=0 SHALL go to DONE, so PREADY rises exactly WAIT_CYCLES+1 cycles after the first PENABLE=1 edge.
REQ-021 DONE SHALL hold PREADY=1 for exactly one cycle, then go to SETUP if PSEL=1 and PENABLE=0 (back-to-back), else IDLE.
REQ-022 PSEL dropping in WAIT SHALL abort to IDLE, with no write and PREADY never asserted.
REQ-023 Decode: index = PADDR[ADDR_W-1:2]; address valid iff PADDR[1:0]=0 and index < NUM_REGS.
REQ-024 Write SHALL commit on the WAIT->DONE edge only if address valid and RO_MASK[index]=0.
REQ-025 Read SHALL load PRDATA with reg[index] on the WAIT->DONE edge if address valid; else PRDATA SHALL load 0.
REQ-026 PSLVERR=1 in DONE for invalid address, or for a write to a read-only register; the write is then dropped.
REQ-027 PRDATA SHALL hold its value outside DONE; PREADY=0 and PSLVERR=0 in every state except DONE.
REQ-028 PADDR, PWRITE, PWDATA and PSTRB SHALL be sampled on the SETUP->WAIT edge; later changes SHALL be ignored.

Reset
REQ-029 PRESET=1 at an edge SHALL force IDLE, counter=0, all registers=0, PRDATA=0, PREADY=0 and PSLVERR=0, overriding any transfer in progress, including a write about to commit.

Configuration
REQ-030 With macro APB_PSTRB_EN defined, a write SHALL update only byte lanes whose PSTRB bit is 1, and a read SHALL signal PSLVERR if PSTRB is not all-zero. Without the macro, PSTRB SHALL be ignored and writes update all bytes.

Verification
REQ-031 Defaults: write 0xDEADBEEF to 0x04, then read 0x04 -> PREADY high one cycle after PENABLE; PRDATA=0xDEADBEEF; PSLVERR=0.
REQ-032 WAIT_CYCLES=3: read 0x00 -> PREADY low 3 cycles, high on the 4th cycle after the PENABLE edge, for one cycle.
REQ-033 Read 0x20 (index 8, NUM_REGS=8) and 0x02 (misaligned) -> PSLVERR=1 and PRDATA=0 in both cases.
REQ-034 RO_MASK=0x01: write 0x12345678 to 0x00 -> PSLVERR=1; a following read returns 0x00000000.
REQ-035 APB_PSTRB_EN defined: reg at 0x08 = 0xFFFFFFFF; write 0x00000000 with PSTRB=0b0101 -> read returns 0xFF00FF00.
REQ-036 PRESET asserted in WAIT of a write of 0xA5A5A5A5 to 0x0C -> PREADY stays 0; a later read of 0x0C returns 0.

Source files
------------

// File: rtl/apb_regfile_slave_if.sv
// APB bus bundle for apb_regfile_slave: master drives the request, slave returns
// registered read data, ready and error.
interface apb_regfile_slave_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [STRB_W-1:0] PSTRB;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_regfile_slave.sv
// APB register file slave with programmable wait states and read-only mask.
// Optional macro APB_PSTRB_EN enables byte-lane write strobes and read strobe checking.
module apb_regfile_slave #(
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          ADDR_W      = 8,
  parameter int unsigned          NUM_REGS    = 8,
  parameter int unsigned          WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = '0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  apb_regfile_slave_if.slave    bus
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDXF_W = ADDR_W - 2;
  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic              write_q,   write_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [DATA_W-1:0] prdata_q,  prdata_d;
  logic              pready_q,  pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic [IDXF_W-1:0] idx_full_c;
  logic [IDX_W-1:0]  idx_c;
  logic              addr_ok_c;
  logic              rd_strb_err_c;
  logic              err_c;
  logic [DATA_W-1:0] wmerge_c;

  // Decode of the address captured at the start of the access phase
  assign idx_full_c = addr_q[ADDR_W-1:2];
  assign idx_c      = IDX_W'(idx_full_c);
  assign addr_ok_c  = (addr_q[1:0] == 2'b00) && (32'(idx_full_c) < NUM_REGS);

`ifdef APB_PSTRB_EN
  logic [STRB_W-1:0] strb_q, strb_d;

  assign rd_strb_err_c = !write_q && (strb_q != '0);

  always_comb begin
    wmerge_c = regs_q[idx_c];
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (strb_q[b]) wmerge_c[b*8 +: 8] = wdata_q[b*8 +: 8];
    end
  end
`else
  logic unused_pstrb;

  assign unused_pstrb  = ^bus.PSTRB;
  assign rd_strb_err_c = 1'b0;
  assign wmerge_c      = wdata_q;
`endif

  assign err_c = !addr_ok_c || (write_q && RO_MASK[idx_c]) || rd_strb_err_c;

  // Next-state, capture and commit logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    pslverr_d = 1'b0;
    regs_d    = regs_q;
`ifdef APB_PSTRB_EN
    strb_d    = strb_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.PSEL && !bus.PENABLE) begin
          state_d = S_SETUP;
        end else if (bus.PSEL && bus.PENABLE) begin
          // Access phase without a setup phase: error out, touch nothing
          state_d   = S_DONE;
          pslverr_d = 1'b1;
        end
      end
      S_SETUP: begin
        if (!bus.PSEL) begin
          state_d = S_IDLE;
        end else if (bus.PENABLE) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          addr_d  = bus.PADDR;
          write_d = bus.PWRITE;
          wdata_d = bus.PWDATA;
`ifdef APB_PSTRB_EN
          strb_d  = bus.PSTRB;
`endif
        end
      end
      S_WAIT: begin
        if (!bus.PSEL) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d   = S_DONE;
          pslverr_d = err_c;
          if (write_q) begin
            if (!err_c) regs_d[idx_c] = wmerge_c;
          end else begin
            prdata_d = addr_ok_c ? regs_q[idx_c] : '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = (bus.PSEL && !bus.PENABLE) ? S_SETUP : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    pready_d = (state_d == S_DONE);
    if (state_d != S_DONE) pslverr_d = 1'b0;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      regs_q    <= '{default: '0};
`ifdef APB_PSTRB_EN
      strb_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      regs_q    <= regs_d;
`ifdef APB_PSTRB_EN
      strb_q    <= strb_d;
`endif
    end
  end

  assign bus.PRDATA  = prdata_q;
  assign bus.PREADY  = pready_q;
  assign bus.PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Randomised scoreboard bench for apb_regfile_slave (WAIT_CYCLES=3, register 0 read-only).
module tb_apb_regfile_slave;

  localparam int unsigned NREGS   = 8;
  localparam int unsigned TB_WAIT = 3;
  localparam logic [7:0]  TB_RO   = 8'h01;

  typedef struct {
    int          ready_cyc;
    logic [31:0] prdata;
    logic        pslverr;
  } exp_t;

  logic PCLK = 1'b0;
  logic PRESET;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  exp_t        exp_q[$];
  logic [31:0] m_regs [NREGS];
  logic [31:0] last_prdata;
  logic [7:0]  ro_mask;

  apb_regfile_slave_if #(.DATA_W(32), .ADDR_W(8)) bus ();

  apb_regfile_slave #(
    .DATA_W(32), .ADDR_W(8), .NUM_REGS(NREGS),
    .WAIT_CYCLES(TB_WAIT), .RO_MASK(TB_RO)
  ) dut (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .bus(bus)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: registers as a plain array, decode by arithmetic on the byte address
  task automatic model_reset();
    for (int i = 0; i < int'(NREGS); i++) m_regs[i] = '0;
    last_prdata = '0;
  endtask

  task automatic model(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, output exp_t e);
    int idx;
    bit ok;
    idx = int'(addr) / 4;
    ok  = (int'(addr) % 4 == 0) && (idx < int'(NREGS));
    e.pslverr = !ok;
    e.prdata  = last_prdata;
    e.ready_cyc = 0;
    if (wr) begin
      if (ok && ro_mask[idx]) begin
        e.pslverr = 1'b1;
      end else if (ok) begin
`ifdef APB_PSTRB_EN
        for (int b = 0; b < 4; b++) if (strb[b]) m_regs[idx][8*b +: 8] = data[8*b +: 8];
`else
        m_regs[idx] = data;
`endif
      end
    end else begin
      if (ok) last_prdata = m_regs[idx];
      else    last_prdata = '0;
      e.prdata = last_prdata;
`ifdef APB_PSTRB_EN
      if (strb != 4'b0) e.pslverr = 1'b1;
`endif
    end
  endtask

  // Monitor: every PREADY pulse must match the oldest outstanding expectation
  always @(negedge PCLK) begin
    exp_t e;
    if (bus.PREADY === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pready: got PREADY=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("pready_cycle", 64'(cyc), 64'(e.ready_cyc));
        chk("prdata", 64'(bus.PRDATA), 64'(e.prdata));
        chk("pslverr", 64'(bus.PSLVERR), 64'(e.pslverr));
      end
    end else if (bus.PSLVERR !== 1'b0) begin
      n_tests++;
      n_fail++;
      $display("FAIL pslverr_idle: got PSLVERR=%b expected 0 (cycle %0d)", bus.PSLVERR, cyc);
    end
  end

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle(input int n);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    repeat (n) step();
  endtask

  // Full transfer; returns in the PREADY cycle so the caller may chain back-to-back
  task automatic xfer(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                      input logic [3:0] strb);
    exp_t e;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
    bus.PADDR = addr; bus.PWDATA = data; bus.PSTRB = strb;
    step();
    bus.PENABLE = 1'b1;
    step();
    model(wr, addr, data, strb, e);
    e.ready_cyc = cyc + int'(TB_WAIT) + 1;
    exp_q.push_back(e);
    bus.PWRITE = 1'($urandom); bus.PADDR = 8'($urandom);
    bus.PWDATA = $urandom;     bus.PSTRB = 4'($urandom);
    for (int k = 0; k < 40 && bus.PREADY !== 1'b1; k++) step();
    if (bus.PREADY !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL pready_timeout: got PREADY=%b expected 1 (cycle %0d)", bus.PREADY, cyc);
    end
  endtask

  task automatic no_setup_access();
    exp_t e;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b1;
    bus.PADDR = 8'h04; bus.PWDATA = $urandom; bus.PSTRB = 4'hF;
    step();
    e.ready_cyc = cyc;
    e.prdata    = last_prdata;
    e.pslverr   = 1'b1;
    exp_q.push_back(e);
    idle(2);
  endtask

  task automatic abort_write(input logic [7:0] addr, input logic [31:0] data);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = addr; bus.PWDATA = data; bus.PSTRB = 4'hF;
    step();
    bus.PENABLE = 1'b1;
    step();
    step();
    idle(TB_WAIT + 2);
  endtask

  task automatic check_reset_outputs();
    @(negedge PCLK);
    chk("rst_prdata", 64'(bus.PRDATA), 64'h0);
    chk("rst_pready", 64'(bus.PREADY), 64'h0);
    chk("rst_pslverr", 64'(bus.PSLVERR), 64'h0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    bit in_done;
    int op;
    logic [7:0] a;
    bit wr;
    logic [3:0] s;

    ro_mask = TB_RO;
    model_reset();
    PRESET = 1'b1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0; bus.PWDATA = '0; bus.PSTRB = '0;
    repeat (3) step();
    PRESET = 1'b0;
    check_reset_outputs();

    // Directed: write/read, out of range, misaligned, read-only, strobes
    xfer(1'b1, 8'h04, 32'hDEADBEEF, 4'hF); idle(1);
    xfer(1'b0, 8'h04, 32'h0, 4'h0);        idle(1);
    xfer(1'b0, 8'h20, 32'h0, 4'h0);        idle(1);
    xfer(1'b0, 8'h04, 32'h0, 4'h0);
    xfer(1'b0, 8'h02, 32'h0, 4'h0);        idle(1);
    xfer(1'b1, 8'h00, 32'h12345678, 4'hF); idle(1);
    xfer(1'b0, 8'h00, 32'h0, 4'h0);        idle(1);
    xfer(1'b1, 8'h08, 32'hFFFFFFFF, 4'hF);
    xfer(1'b1, 8'h08, 32'h00000000, 4'b0101);
    xfer(1'b0, 8'h08, 32'h0, 4'h0);        idle(1);
    xfer(1'b0, 8'h08, 32'h0, 4'h3);        idle(1);
    no_setup_access();
    abort_write(8'h04, 32'h0BADF00D);
    xfer(1'b0, 8'h04, 32'h0, 4'h0);        idle(1);

    // Randomised mix including back-to-back, aborts and setup-less accesses
    in_done = 1'b0;
    for (int i = 0; i < 150; i++) begin
      op = int'($urandom_range(0, 9));
      if (op < 2 && in_done) begin
        idle(1);
        in_done = 1'b0;
      end
      if (op == 0) begin
        abort_write(8'($urandom_range(0, 7) * 4), $urandom);
      end else if (op == 1) begin
        no_setup_access();
      end else begin
        a  = 8'($urandom_range(0, 39));
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        wr = 1'($urandom);
        s  = 4'($urandom);
        if (!wr && $urandom_range(0, 4) != 0) s = 4'h0;
        xfer(wr, a, $urandom, s);
        in_done = 1'b1;
        if ($urandom_range(0, 1) == 0) begin
          idle(1);
          in_done = 1'b0;
        end
      end
    end
    if (in_done) idle(1);

    // Reset while a write sits one edge from committing
    xfer(1'b0, 8'h04, 32'h0, 4'h0); idle(1);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 8'h0C; bus.PWDATA = 32'hA5A5A5A5; bus.PSTRB = 4'hF;
    step();
    bus.PENABLE = 1'b1;
    step();
    repeat (TB_WAIT) step();
    PRESET = 1'b1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    step();
    PRESET = 1'b0;
    model_reset();
    check_reset_outputs();
    for (int r = 0; r < int'(NREGS); r++) begin
      xfer(1'b0, 8'(r * 4), 32'h0, 4'h0);
      idle(1);
    end

    idle(4);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
